// File: rtl/stack_pkg.sv
// Shared constants and helpers for the parametrised LIFO stack (param_stack).
package stack_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 128;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE = 2'd0;
  localparam err_code_t ERR_OVF  = 2'd1;
  localparam err_code_t ERR_UNF  = 2'd2;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Simple dual-port synchronous RAM with read-before-write and a resettable
// read register; the array itself is never reset so it maps onto block RAM.
module stack_ram
  import stack_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic              rrst,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port; non-blocking semantics return the old word on a same-address write.
  always_ff @(posedge clk) begin
    if (rrst) begin
      rdata <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with status, sticky error flags and pop qualifiers.
// Optional macro PARAM_STACK_IRQ_EN adds a one-cycle err_irq pulse per error.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic             hold,
  input  logic             err_clr,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
`ifdef PARAM_STACK_IRQ_EN
  ,
  output logic             err_irq
`endif
);

  localparam int CNT_W = count_width(DEPTH);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             overflow_r;
  logic             underflow_r;
  logic [PTR_W-1:0] ptr_s;
  logic [PTR_W-1:0] top_s;
  logic [PTR_W-1:0] waddr_s;
  logic             full_s;
  logic             empty_s;
  logic             eff_pop_s;
  logic             we_s;
  logic             re_s;
  logic             zero_q_s;
  err_code_t        err_s;

  assign ptr_s   = count_r[PTR_W-1:0];
  assign top_s   = ptr_s - PTR_W'(1);
  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // Decode the request into RAM strobes, next occupancy and error event.
  always_comb begin
    eff_pop_s   = pop && !clear && !hold;
    we_s        = 1'b0;
    re_s        = 1'b0;
    zero_q_s    = 1'b0;
    waddr_s     = ptr_s;
    count_nxt_s = count_r;
    err_s       = ERR_NONE;
    if (eff_pop_s && !empty_s) begin
      re_s = 1'b1;
      if (push) begin
        // Replace-top: read and overwrite the same word in one cycle.
        we_s    = 1'b1;
        waddr_s = top_s;
      end else begin
        count_nxt_s = count_r - CNT_W'(1);
      end
    end else begin
      if (eff_pop_s) begin
        zero_q_s = 1'b1;
        err_s    = ERR_UNF;
      end else if (pop && clear) begin
        zero_q_s = 1'b1;
      end else begin
        zero_q_s = 1'b0;
      end
      if (push && !full_s) begin
        we_s        = 1'b1;
        count_nxt_s = count_r + CNT_W'(1);
      end else if (push) begin
        err_s = ERR_OVF;
      end else begin
        count_nxt_s = count_r;
      end
    end
  end

  // Occupancy and sticky error flags; a new event outranks err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      overflow_r  <= (err_s == ERR_OVF) || (overflow_r && !err_clr);
      underflow_r <= (err_s == ERR_UNF) || (underflow_r && !err_clr);
    end
  end

`ifdef PARAM_STACK_IRQ_EN
  logic err_irq_r;

  // One-cycle pulse following any overflow or underflow event.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_irq_r <= 1'b0;
    end else begin
      err_irq_r <= (err_s != ERR_NONE);
    end
  end

  assign err_irq = err_irq_r;
`endif

  stack_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we_s && !reset),
    .waddr (waddr_s),
    .wdata (d),
    .re    (re_s && !reset),
    .rrst  (reset || zero_q_s),
    .raddr (top_s),
    .rdata (q)
  );

  assign count     = count_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule
